// File: rtl/time_digit_setter_pkg.sv
// Shared time constants: FSM encodings, cursor codes, per-digit wrap limits and BCD-pair conversion.
// Pure declarations; no latency or flow-control behaviour.
package time_digit_setter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CUR_H10 = 2'd0,
    CUR_H1  = 2'd1,
    CUR_M10 = 2'd2,
    CUR_M1  = 2'd3
  } cursor_t;

  localparam logic [3:0] LIM_H10      = 4'd2;
  localparam logic [3:0] LIM_H1       = 4'd9;
  localparam logic [3:0] LIM_H1_AT_20 = 4'd3;
  localparam logic [3:0] LIM_M10      = 4'd5;
  localparam logic [3:0] LIM_M1       = 4'd9;

  // Wider intermediate keeps out-of-range captured digits well defined before truncation.
  function automatic logic [5:0] bcd_pair_to_bin(input logic [3:0] tens, input logic [3:0] units);
    return 6'(8'(tens) * 8'd10 + 8'(units));
  endfunction

endpackage

// File: rtl/time_digit_setter_if.sv
// Button, current-time and edit/commit signal bundle for the time digit setter.
// master drives buttons and current time; slave is the setter itself.
interface time_digit_setter_if;
  logic [3:0] i_hour_10;
  logic [3:0] i_hour_1;
  logic [3:0] i_min_10;
  logic [3:0] i_min_1;
  logic       i_btn_mode;
  logic       i_btn_next;
  logic       i_btn_up;
  logic [3:0] o_edit_hour_10;
  logic [3:0] o_edit_hour_1;
  logic [3:0] o_edit_min_10;
  logic [3:0] o_edit_min_1;
  logic [1:0] o_cursor;
  logic       o_set_mode;
  logic [5:0] o_hour;
  logic [5:0] o_min;
  logic       o_load;

  modport master (
    output i_hour_10, i_hour_1, i_min_10, i_min_1,
    output i_btn_mode, i_btn_next, i_btn_up,
    input  o_edit_hour_10, o_edit_hour_1, o_edit_min_10, o_edit_min_1,
    input  o_cursor, o_set_mode, o_hour, o_min, o_load
  );

  modport slave (
    input  i_hour_10, i_hour_1, i_min_10, i_min_1,
    input  i_btn_mode, i_btn_next, i_btn_up,
    output o_edit_hour_10, o_edit_hour_1, o_edit_min_10, o_edit_min_1,
    output o_cursor, o_set_mode, o_hour, o_min, o_load
  );
endinterface

// File: rtl/bcd_digit_inc.sv
// Combinational BCD digit increment with wrap to 0 at or beyond a given limit.
// Zero latency; no flow control.
module bcd_digit_inc (
  input  logic [3:0] digit,
  input  logic [3:0] limit,
  output logic [3:0] next_digit
);
  // ">=" so an out-of-range digit wraps to 0 on its first increment.
  assign next_digit = (digit >= limit) ? 4'd0 : digit + 4'd1;
endmodule

// File: rtl/time_digit_setter.sv
// Four-digit HH:MM editor: capture on mode, cursor/up editing, commit to binary with a one-cycle load pulse.
// Commit press on cycle N gives o_load and new o_hour/o_min on cycle N+2; buttons are pulses, no backpressure.
module time_digit_setter
  import time_digit_setter_pkg::*;
(
  input logic                 i_clk,
  input logic                 i_reset_n,
  time_digit_setter_if.slave  s
);

  state_t     state_q, state_d;
  cursor_t    cursor_q, cursor_d;
  logic [3:0] h10_q, h1_q, m10_q, m1_q;
  logic [3:0] h10_d, h1_d, m10_d, m1_d;
  logic [3:0] h10_inc, h1_inc, m10_inc, m1_inc;
  logic [3:0] h1_lim;
  logic [5:0] hour_q, min_q;
  logic       load_q, set_mode_q;

  assign h1_lim = (h10_q == LIM_H10) ? LIM_H1_AT_20 : LIM_H1;

  bcd_digit_inc u_inc_h10 (.digit(h10_q), .limit(LIM_H10), .next_digit(h10_inc));
  bcd_digit_inc u_inc_h1  (.digit(h1_q),  .limit(h1_lim),  .next_digit(h1_inc));
  bcd_digit_inc u_inc_m10 (.digit(m10_q), .limit(LIM_M10), .next_digit(m10_inc));
  bcd_digit_inc u_inc_m1  (.digit(m1_q),  .limit(LIM_M1),  .next_digit(m1_inc));

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    h10_d    = h10_q;
    h1_d     = h1_q;
    m10_d    = m10_q;
    m1_d     = m1_q;
    case (state_q)
      IDLE: begin
        if (s.i_btn_mode) begin
          h10_d    = s.i_hour_10;
          h1_d     = s.i_hour_1;
          m10_d    = s.i_min_10;
          m1_d     = s.i_min_1;
          cursor_d = CUR_H10;
          state_d  = EDIT;
        end
      end
      EDIT: begin
        if (s.i_btn_mode) begin
          state_d = COMMIT;
        end else if (s.i_btn_next) begin
          cursor_d = cursor_t'(cursor_q + 2'd1);
        end else if (s.i_btn_up) begin
          case (cursor_q)
            CUR_H10: begin
              h10_d = h10_inc;
              // Moving into the 20s clamps the units so the hour stays at most 23.
              if (h10_inc == LIM_H10 && h1_q > LIM_H1_AT_20) h1_d = LIM_H1_AT_20;
            end
            CUR_H1:  h1_d  = h1_inc;
            CUR_M10: m10_d = m10_inc;
            default: m1_d  = m1_inc;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      cursor_q   <= CUR_H10;
      h10_q      <= 4'd0;
      h1_q       <= 4'd0;
      m10_q      <= 4'd0;
      m1_q       <= 4'd0;
      hour_q     <= 6'd0;
      min_q      <= 6'd0;
      load_q     <= 1'b0;
      set_mode_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cursor_q   <= cursor_d;
      h10_q      <= h10_d;
      h1_q       <= h1_d;
      m10_q      <= m10_d;
      m1_q       <= m1_d;
      load_q     <= (state_q == COMMIT);
      set_mode_q <= (state_d == EDIT);
      if (state_q == COMMIT) begin
        hour_q <= bcd_pair_to_bin(h10_q, h1_q);
        min_q  <= bcd_pair_to_bin(m10_q, m1_q);
      end
    end
  end

  assign s.o_edit_hour_10 = h10_q;
  assign s.o_edit_hour_1  = h1_q;
  assign s.o_edit_min_10  = m10_q;
  assign s.o_edit_min_1   = m1_q;
  assign s.o_cursor       = cursor_q;
  assign s.o_set_mode     = set_mode_q;
  assign s.o_hour         = hour_q;
  assign s.o_min          = min_q;
  assign s.o_load         = load_q;

endmodule

// File: tb/tb_time_digit_setter.sv
// Bench for time_digit_setter: directed scenarios plus randomized button/time traffic
// compared every cycle against a behavioural model of the editor.
module tb_time_digit_setter;

  logic i_clk;
  logic i_reset_n;

  time_digit_setter_if ifc ();

  time_digit_setter dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .s         (ifc)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: phase 0 = idle, 1 = editing, 2 = committing
  int m_phase;
  int m_dig[4];
  int m_cur;
  int m_hour, m_min;
  bit m_load, m_setm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int digit_limit(input int idx, input int h10);
    case (idx)
      0:       return 2;
      1:       return (h10 == 2) ? 3 : 9;
      2:       return 5;
      default: return 9;
    endcase
  endfunction

  task automatic model_edge(input bit rst_n, input bit mode, input bit next, input bit up,
                            input int d0, input int d1, input int d2, input int d3);
    bit was_commit;
    int lim;
    if (!rst_n) begin
      m_phase = 0; m_cur = 0; m_dig = '{0, 0, 0, 0};
      m_hour = 0; m_min = 0; m_load = 0; m_setm = 0;
      return;
    end
    was_commit = (m_phase == 2);
    if (was_commit) begin
      m_hour = (m_dig[0] * 10 + m_dig[1]) % 64;
      m_min  = (m_dig[2] * 10 + m_dig[3]) % 64;
    end
    if (m_phase == 0) begin
      if (mode) begin
        m_dig = '{d0, d1, d2, d3};
        m_cur = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (mode) m_phase = 2;
      else if (next) m_cur = (m_cur + 1) % 4;
      else if (up) begin
        lim = digit_limit(m_cur, m_dig[0]);
        m_dig[m_cur] = (m_dig[m_cur] >= lim) ? 0 : m_dig[m_cur] + 1;
        if (m_cur == 0 && m_dig[0] == 2 && m_dig[1] > 3) m_dig[1] = 3;
      end
    end else begin
      m_phase = 0;
    end
    m_load = was_commit;
    m_setm = (m_phase == 1);
  endtask

  task automatic compare_all();
    chk("edit_digits", {ifc.o_edit_hour_10, ifc.o_edit_hour_1, ifc.o_edit_min_10, ifc.o_edit_min_1},
        {4'(m_dig[0]), 4'(m_dig[1]), 4'(m_dig[2]), 4'(m_dig[3])});
    chk("cursor",   32'(ifc.o_cursor),   32'(m_cur));
    chk("set_mode", 32'(ifc.o_set_mode), 32'(m_setm));
    chk("load",     32'(ifc.o_load),     32'(m_load));
    chk("hour",     32'(ifc.o_hour),     32'(m_hour));
    chk("min",      32'(ifc.o_min),      32'(m_min));
  endtask

  task automatic set_time(input int h10, input int h1, input int m10, input int m1);
    ifc.i_hour_10 = 4'(h10);
    ifc.i_hour_1  = 4'(h1);
    ifc.i_min_10  = 4'(m10);
    ifc.i_min_1   = 4'(m1);
  endtask

  // One clock: drive at negedge, update model at posedge, compare at following negedge.
  task automatic step(input bit rst_n, input bit mode, input bit next, input bit up);
    i_reset_n      = rst_n;
    ifc.i_btn_mode = mode;
    ifc.i_btn_next = next;
    ifc.i_btn_up   = up;
    @(posedge i_clk);
    model_edge(rst_n, mode, next, up, int'(ifc.i_hour_10), int'(ifc.i_hour_1),
               int'(ifc.i_min_10), int'(ifc.i_min_1));
    @(negedge i_clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0);
  endtask

  int h1_seq[5] = '{6, 7, 8, 9, 0};
  int h10r;

  initial begin
    set_time(0, 0, 0, 0);
    i_reset_n = 1'b0;
    ifc.i_btn_mode = 0; ifc.i_btn_next = 0; ifc.i_btn_up = 0;
    @(negedge i_clk);
    step(0, 0, 0, 0);
    step(0, 1, 1, 1);
    chk("rst_hour", 32'(ifc.o_hour), 0);
    chk("rst_set_mode", 32'(ifc.o_set_mode), 0);

    // 12:34 straight commit
    set_time(1, 2, 3, 4);
    step(1, 1, 0, 0);
    chk("enter_edit", 32'(ifc.o_set_mode), 1);
    step(1, 1, 0, 0);
    chk("commit_no_load_yet", 32'(ifc.o_load), 0);
    step(1, 0, 0, 0);
    chk("load_pulse", 32'(ifc.o_load), 1);
    chk("hour_12", 32'(ifc.o_hour), 12);
    chk("min_34", 32'(ifc.o_min), 34);
    idle(1);
    chk("load_drop", 32'(ifc.o_load), 0);
    chk("hour_hold", 32'(ifc.o_hour), 12);

    // H1 wraps 9 -> 0 when H10 is 1
    set_time(1, 5, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 0, 1);
      chk("h1_seq", 32'(ifc.o_edit_hour_1), 32'(h1_seq[k]));
    end
    step(1, 1, 0, 0);
    idle(1);
    chk("hour_10", 32'(ifc.o_hour), 10);

    // H10 -> 2 clamps H1 to 3
    set_time(1, 7, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 1);
    chk("h10_to_2", 32'(ifc.o_edit_hour_10), 2);
    chk("h1_clamped", 32'(ifc.o_edit_hour_1), 3);
    step(1, 1, 0, 0);
    idle(1);
    chk("hour_23", 32'(ifc.o_hour), 23);

    // M10 wrap and full cursor rotation
    set_time(0, 0, 5, 0);
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    chk("cursor_2", 32'(ifc.o_cursor), 2);
    step(1, 0, 0, 1);
    chk("m10_wrap", 32'(ifc.o_edit_min_10), 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    chk("cursor_back_0", 32'(ifc.o_cursor), 0);
    for (int k = 1; k <= 4; k++) begin
      step(1, 0, 1, 0);
      chk("cursor_rot", 32'(ifc.o_cursor), 32'(k % 4));
    end
    step(1, 1, 0, 0);
    idle(2);

    // Priority: mode beats up; up/next ignored in idle
    set_time(1, 2, 3, 4);
    step(1, 1, 0, 0);
    step(1, 1, 1, 1);
    chk("prio_digits", {ifc.o_edit_hour_10, ifc.o_edit_hour_1, ifc.o_edit_min_10, ifc.o_edit_min_1}, 32'h1234);
    chk("prio_left_edit", 32'(ifc.o_set_mode), 0);
    step(1, 1, 1, 1);
    chk("commit_ignores_mode", 32'(ifc.o_set_mode), 0);
    step(1, 0, 1, 1);
    chk("idle_ignores_btn", {ifc.o_edit_hour_10, ifc.o_edit_hour_1, ifc.o_edit_min_10, ifc.o_edit_min_1}, 32'h1234);

    // Out-of-range captured H10 wraps on first up
    set_time(3, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("oor_captured", 32'(ifc.o_edit_hour_10), 3);
    step(1, 0, 0, 1);
    chk("oor_wrap", 32'(ifc.o_edit_hour_10), 0);

    // Reset aborts edit and commit
    step(0, 1, 0, 0);
    chk("rst_in_edit", 32'(ifc.o_set_mode), 0);
    chk("rst_in_edit_load", 32'(ifc.o_load), 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_in_commit_load", 32'(ifc.o_load), 0);
    idle(1);
    chk("rst_commit_no_load", 32'(ifc.o_load), 0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        set_time($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      end else begin
        h10r = $urandom_range(0, 2);
        set_time(h10r, (h10r == 2) ? $urandom_range(0, 3) : $urandom_range(0, 9),
                 $urandom_range(0, 5), $urandom_range(0, 9));
      end
      step($urandom_range(0, 199) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/time_digit_setter.md
TIME_DIGIT_SETTER -- requirements
Module: time_digit_setter

Interface
REQ-001 SHALL have port i_clk, input, 1, sole system clock, rising-edge active.
REQ-002 SHALL have port i_reset_n, input, 1, synchronous active-low reset.
REQ-003 SHALL have ports i_hour_10, i_hour_1, i_min_10, i_min_1, input, 4 each, current time as BCD digits (digit-divider outputs).
REQ-004 SHALL have port i_btn_mode, input, 1, one-cycle pulse: enter set mode / commit.
REQ-005 SHALL have port i_btn_next, input, 1, one-cycle pulse: advance cursor.
REQ-006 SHALL have port i_btn_up, input, 1, one-cycle pulse: increment digit under cursor.
REQ-007 SHALL have ports o_edit_hour_10, o_edit_hour_1, o_edit_min_10, o_edit_min_1, output, 4 each, digits being edited.
REQ-008 SHALL have port o_cursor, output, 2, 0=H10, 1=H1, 2=M10, 3=M1.
REQ-009 SHALL have port o_set_mode, output, 1, high while editing.
REQ-010 SHALL have ports o_hour, o_min, output, 6 each, binary committed time.
REQ-011 SHALL have port o_load, output, 1, one-cycle pulse: o_hour/o_min valid for loading into the time counter.

Function
REQ-012 SHALL implement states IDLE, EDIT, COMMIT; all outputs registered.
REQ-013 IDLE + i_btn_mode: SHALL capture all four i_* digits into edit registers, set o_cursor=0, enter EDIT next cycle.
REQ-014 EDIT + i_btn_next: o_cursor SHALL advance 0->1->2->3->0.
REQ-015 EDIT + i_btn_up: selected digit SHALL increment by 1 and wrap to 0 past its limit: H10 max 2; H1 max 9, or 3 when H10=2; M10 max 5; M1 max 9.
REQ-016 Incrementing H10 to 2 while H1>3 SHALL force H1 to 3 in the same cycle.
REQ-017 EDIT + i_btn_mode: SHALL enter COMMIT; COMMIT SHALL last exactly one cycle, then return to IDLE.
REQ-018 In COMMIT: o_hour SHALL equal H10*10+H1 and o_min SHALL equal M10*10+M1, computed in 6 bits with no overflow (max 23, 59). o_load SHALL be 1 for that cycle only.
REQ-019 o_hour/o_min SHALL hold their last committed values until the next commit.
REQ-020 Latency: commit pulse on cycle N -> o_load and new o_hour/o_min on cycle N+2.
REQ-021 Simultaneous buttons: priority mode > next > up; a lower-priority pulse in the same cycle SHALL be ignored.
REQ-022 i_btn_next and i_btn_up SHALL be ignored in IDLE and COMMIT; i_btn_mode SHALL be ignored in COMMIT.
REQ-023 o_set_mode SHALL be 1 in EDIT only.
REQ-024 Out-of-range captured digits (e.g. H10=3) SHALL be used unchanged until edited; the next up on that digit SHALL wrap it to 0.

Reset
REQ-025 With i_reset_n=0 at a clock edge: state IDLE, o_cursor=0, edit digits=0, o_hour=0, o_min=0, o_load=0, o_set_mode=0.
REQ-026 Reset during EDIT or COMMIT SHALL abort without asserting o_load.

Structure
REQ-027 State encodings, cursor codes and per-digit limits (2, 9, 3, 5, 9) SHALL live in the shared time-constants include, used by all time blocks.
REQ-028 SHALL contain one sub-module, bcd_digit_inc (digit, limit -> wrapped next digit), instantiated once per digit.
REQ-029 Total RTL SHALL be 120-400 lines.

Verification
REQ-030 Digits 1,2,3,4; mode; mode -> o_load pulse with o_hour=12, o_min=34.
REQ-031 Digits 1,5,0,0; mode; next; up x5 -> H1 sequence 6,7,8,9,0; commit -> o_hour=10.
REQ-032 Digits 1,7,0,0; mode; up (H10->2) -> H1 forced to 3; commit -> o_hour=23.
REQ-033 Cursor at 2, M10=5; up -> M10=0; four nexts from 0 -> cursor returns to 0.
REQ-034 mode+up in the same EDIT cycle -> COMMIT, digits unchanged; up/next in IDLE -> no change.
REQ-035 Reset asserted in EDIT -> outputs at reset values next cycle, o_load never asserted.
